// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state codes, opcode/funct constants and control-field codes for mc_ctrl
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXE  = 4'd7,
    S_RTWB   = 4'd8,
    S_BRANCH = 4'd9,
    S_ITEXE  = 4'd10,
    S_ITWB   = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  // Which ALUOp source a state wants: fixed add/sub, funct field, or immediate opcode
  typedef enum logic [1:0] {
    AC_ADD   = 2'd0,
    AC_SUB   = 2'd1,
    AC_FUNCT = 2'd2,
    AC_IMM   = 2'd3
  } alu_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_OR   = 6'b100101;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_OR  = 2'b10;

  localparam logic [1:0] SRCB_RT   = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_SIMM = 2'b10;
  localparam logic [1:0] SRCB_ZIMM = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mc_ctrl_aludec.sv
// rtl/mc_ctrl_aludec.sv - combinational ALUOp decode from state class, opcode and funct
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  alu_class_t  cls,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  output logic [1:0]  aluop,
  output logic        funct_bad
);

  always_comb begin
    aluop     = ALUOP_ADD;
    funct_bad = 1'b0;
    case (cls)
      AC_SUB: aluop = ALUOP_SUB;
      AC_IMM: aluop = (op == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
      AC_FUNCT: begin
        case (funct)
          F_ADD, F_ADDU: aluop = ALUOP_ADD;
          F_SUB, F_SUBU: aluop = ALUOP_SUB;
          F_OR:          aluop = ALUOP_OR;
          default:       funct_bad = 1'b1;
        endcase
      end
      default: aluop = ALUOP_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle MIPS main controller; MC_CTRL_BNE_EN adds bne through BRANCH
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int RESET_PC_HOLD = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_PC_HOLD - 1);

  state_t     state_q, state_d;
  logic [3:0] idle_cnt;
  alu_class_t alu_cls;
  logic       funct_bad;
  logic       bne_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      idle_cnt <= 4'd0;
    end else begin
      state_q  <= state_d;
      idle_cnt <= (state_q == S_IDLE) ? idle_cnt + 4'd1 : 4'd0;
    end
  end

`ifdef MC_CTRL_BNE_EN
  // BRANCH only needs to know beq vs bne; Op is still stable but the flag keeps BRANCH opcode-free
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      bne_q <= 1'b0;
    else if (state_q == S_DECODE)
      bne_q <= (Op == OP_BNE);
  end
`else
  assign bne_q = 1'b0;
`endif

  mc_aludec u_aludec (
    .cls       (alu_cls),
    .op        (Op),
    .funct     (Funct),
    .aluop     (ALUOp),
    .funct_bad (funct_bad)
  );

  assign State = state_q;

  always_comb begin
    state_d  = S_FETCH;
    alu_cls  = AC_ADD;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_RT;
    PCSource = PCS_ALU;
    Illegal  = 1'b0;
    case (state_q)
      S_IDLE:   state_d = (idle_cnt >= HOLD_LAST) ? S_FETCH : S_IDLE;
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_SIMM;
        case (Op)
          OP_LW, OP_SW:     state_d = S_MEMADR;
          OP_RTYPE:         state_d = S_RTEXE;
          OP_BEQ:           state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:           state_d = S_BRANCH;
`endif
          OP_ADDI, OP_ORI:  state_d = S_ITEXE;
          OP_J:             state_d = S_JUMP;
          default: begin
            Illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_SIMM;
        state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTEXE: begin
        ALUSrcA = 1'b1;
        alu_cls = AC_FUNCT;
        Illegal = funct_bad;
        state_d = funct_bad ? S_FETCH : S_RTWB;
      end
      S_RTWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        alu_cls  = AC_SUB;
        PCSource = PCS_ALUOUT;
        PCWrite  = Zero ^ bne_q;
      end
      S_ITEXE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = (Op == OP_ORI) ? SRCB_ZIMM : SRCB_SIMM;
        alu_cls = AC_IMM;
        state_d = S_ITWB;
      end
      S_ITWB:   RegWrite = 1'b1;
      S_JUMP: begin
        PCSource = PCS_JUMP;
        PCWrite  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized scoreboard bench for mc_ctrl with directed branch and reset checks
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, IorD, RegDst, MemtoReg, ALUSrcA, Illegal;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] State;

  always #5 clk = ~clk;

  mc_ctrl #(.RESET_PC_HOLD(1)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp), .Illegal(Illegal), .State(State)
  );

  // {State, PCWrite, IRWrite, MemWrite, RegWrite, IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal}
  wire [18:0] act = {State, PCWrite, IRWrite, MemWrite, RegWrite, IorD, RegDst, MemtoReg,
                     ALUSrcA, ALUSrcB, PCSource, ALUOp, Illegal};

  logic [18:0] expq[$];
  int vectors = 0;
  int miscompares = 0;
  int seqno = 0;
  bit mon_en = 1'b0;

  logic [5:0] op_tab[12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000000, 6'b000100,
                             6'b000101, 6'b001000, 6'b001101, 6'b000010, 6'b111111, 6'b000011};
  logic [5:0] fn_tab[8]  = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100101,
                             6'b101010, 6'b100100, 6'b000000};

  // en = {PCWrite, IRWrite, MemWrite, RegWrite, IorD, RegDst, MemtoReg, ALUSrcA}
  function automatic void push(input logic [3:0] st, input logic [7:0] en, input logic [1:0] srcb,
                               input logic [1:0] pcs, input logic [1:0] aop, input logic ill);
    expq.push_back({st, en, srcb, pcs, aop, ill});
  endfunction

  // Expected per-cycle behaviour of one whole instruction, starting at its FETCH cycle
  function automatic int model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
    logic bne_ok, taken;
    logic [1:0] aop;
    bit fn_ok;
`ifdef MC_CTRL_BNE_EN
    bne_ok = 1'b1;
`else
    bne_ok = 1'b0;
`endif
    push(4'd1, 8'b1100_0000, 2'b01, 2'b00, 2'b00, 1'b0);
    if (op == 6'b100011) begin
      push(4'd2, 8'b0000_0000, 2'b10, 2'b00, 2'b00, 1'b0);
      push(4'd3, 8'b0000_0001, 2'b10, 2'b00, 2'b00, 1'b0);
      push(4'd4, 8'b0000_1000, 2'b00, 2'b00, 2'b00, 1'b0);
      push(4'd5, 8'b0001_0010, 2'b00, 2'b00, 2'b00, 1'b0);
      return 5;
    end else if (op == 6'b101011) begin
      push(4'd2, 8'b0000_0000, 2'b10, 2'b00, 2'b00, 1'b0);
      push(4'd3, 8'b0000_0001, 2'b10, 2'b00, 2'b00, 1'b0);
      push(4'd6, 8'b0010_1000, 2'b00, 2'b00, 2'b00, 1'b0);
      return 4;
    end else if (op == 6'b000000) begin
      push(4'd2, 8'b0000_0000, 2'b10, 2'b00, 2'b00, 1'b0);
      fn_ok = 1;
      if (fn == 6'b100000 || fn == 6'b100001) aop = 2'b00;
      else if (fn == 6'b100010 || fn == 6'b100011) aop = 2'b01;
      else if (fn == 6'b100101) aop = 2'b10;
      else begin aop = 2'b00; fn_ok = 0; end
      push(4'd7, 8'b0000_0001, 2'b00, 2'b00, aop, !fn_ok);
      if (!fn_ok) return 3;
      push(4'd8, 8'b0001_0100, 2'b00, 2'b00, 2'b00, 1'b0);
      return 4;
    end else if (op == 6'b000100 || (op == 6'b000101 && bne_ok)) begin
      push(4'd2, 8'b0000_0000, 2'b10, 2'b00, 2'b00, 1'b0);
      taken = (op == 6'b000101) ? !z : z;
      push(4'd9, {taken, 7'b000_0001}, 2'b00, 2'b01, 2'b01, 1'b0);
      return 3;
    end else if (op == 6'b001000 || op == 6'b001101) begin
      push(4'd2, 8'b0000_0000, 2'b10, 2'b00, 2'b00, 1'b0);
      if (op == 6'b001101) push(4'd10, 8'b0000_0001, 2'b11, 2'b00, 2'b10, 1'b0);
      else                 push(4'd10, 8'b0000_0001, 2'b10, 2'b00, 2'b00, 1'b0);
      push(4'd11, 8'b0001_0000, 2'b00, 2'b00, 2'b00, 1'b0);
      return 4;
    end else if (op == 6'b000010) begin
      push(4'd2, 8'b0000_0000, 2'b10, 2'b00, 2'b00, 1'b0);
      push(4'd12, 8'b1000_0000, 2'b00, 2'b10, 2'b00, 1'b0);
      return 3;
    end
    push(4'd2, 8'b0000_0000, 2'b10, 2'b00, 2'b00, 1'b1);
    return 2;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      seqno++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_underflow cycle=%0d act=%h exp=<none>", seqno, act);
      end else begin
        logic [18:0] e;
        e = expq.pop_front();
        if (act !== e) begin
          miscompares++;
          $display("FAIL seq cycle=%0d Op=%b Funct=%b Zero=%b act=%h exp=%h", seqno, Op, Funct, Zero, act, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [18:0] a, input logic [18:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s act=%h exp=%h", name, a, e);
    end
  endtask

  initial begin
    int n;
    rstn = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", act, 19'd0);
    rstn = 1'b1;
    push(4'd0, 8'b0, 2'b00, 2'b00, 2'b00, 1'b0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      Op    = op_tab[$urandom_range(0, 11)];
      Funct = fn_tab[$urandom_range(0, 7)];
      Zero  = 1'($urandom_range(0, 1));
      n = model_instr(Op, Funct, Zero);
      repeat (n) @(posedge clk);
      #1;
    end
    mon_en = 1'b0;
    check("scoreboard_drained", 19'(expq.size()), 19'd0);

    // beq with Zero toggling inside BRANCH
    Op = 6'b000100; Zero = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("beq_state", 19'(State), 19'd9);
    check("beq_nz_pcwrite", 19'(PCWrite), 19'd0);
    Zero = 1'b1; #1;
    check("beq_z_pcwrite", 19'({PCWrite, PCSource, ALUOp}), 19'b1_01_01);
    Zero = 1'b0; #1;
    check("beq_zfall_pcwrite", 19'(PCWrite), 19'd0);
    @(posedge clk); #1;
    check("beq_to_fetch", 19'(State), 19'd1);

    // reset asserted while in MEMWR
    Op = 6'b101011;
    repeat (3) @(posedge clk); #1;
    check("sw_memwr", 19'({State, MemWrite}), 19'({4'd6, 1'b1}));
    rstn = 1'b0; #1;
    check("sw_reset_async", act, 19'd0);
    repeat (2) @(negedge clk);
    check("sw_reset_held", act, 19'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check("restart_idle", act, 19'd0);
    @(posedge clk); #1;
    check("restart_fetch", 19'({State, PCWrite, IRWrite, ALUSrcB}), 19'({4'd1, 1'b1, 1'b1, 2'b01}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
